// File: rtl/divider_top_if.sv
// Byte-wide pad interface of the serial divider: operand bytes in, result bytes out.
// No latency of its own; it only bundles wires.
// No backpressure: pushes are strobes and results stream out unconditionally.
interface divider_top_if;
   logic [7:0] data_in_in;
   logic       push_in;
   logic       sign;
   logic       select;
   logic [7:0] data_out_out;
   logic       pull_out;
   logic       sign_out;

   // Pad/bus side: drives operands, observes the result stream
   modport master (
      output data_in_in, push_in, sign, select,
      input  data_out_out, pull_out, sign_out
   );

   // Divider side
   modport slave (
      input  data_in_in, push_in, sign, select,
      output data_out_out, pull_out, sign_out
   );
endinterface

// File: rtl/divider_top.sv
// Byte-serial 32-bit divider: 8 pushed bytes -> operand FIFO -> radix-2 SRT core -> 8 result bytes.
// Latency: first result byte 3 + (lz+1) cycles after the op reaches an idle core (at most 35 cycles).
// No backpressure: an op completing while the FIFO is full is dropped; results stream without stalls.
module divider_top #(
   parameter int DATA_WIDTH       = 65,
   parameter int BUFFER_DEPTH     = 4,
   parameter int LOG_BUFFER_DEPTH = 3,
   parameter int WIDTH            = 32,
   parameter int EXPWIDTH         = 6
) (
   input  logic          clk,
   input  logic          rst_n,
   divider_top_if.slave  bus
);

   localparam int SRW = 2 * WIDTH - 8;        // bytes held before the final one arrives
   localparam int WW  = WIDTH + 3;            // partial remainder: 2*W must fit signed
   localparam int AW  = LOG_BUFFER_DEPTH - 1; // FIFO index width without wrap bit

   typedef enum logic [1:0] {C_IDLE, C_ITER, C_CORR, C_DONE} core_state_t;

   // ------------------------------------------------------------------
   // Byte assembly
   // ------------------------------------------------------------------
   logic [2:0]            byte_cnt;
   logic [SRW-1:0]        byte_sr;
   logic                  word_vld;
   logic [DATA_WIDTH-1:0] word_dat;

   // The FP32 mode select behaves exactly like integer mode, so it is not consumed.
   logic unused_select;
   assign unused_select = bus.select;

   // Eighth byte completes a word; sign is taken from that same cycle
   always_comb begin
      word_vld = bus.push_in && (byte_cnt == 3'd7);
      word_dat = {bus.sign, byte_sr, bus.data_in_in};
   end

   // Count pushed bytes and shift them in, most significant first
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         byte_cnt <= '0;
         byte_sr  <= '0;
      end else if (bus.push_in) begin
         byte_cnt <= byte_cnt + 3'd1;
         byte_sr  <= {byte_sr[SRW-9:0], bus.data_in_in};
      end
   end

   // ------------------------------------------------------------------
   // Operand FIFO. The head entry stays resident while the core works on
   // it and is popped only when its result moves to the serializer, so
   // the occupancy includes the operation in flight.
   // ------------------------------------------------------------------
   logic [DATA_WIDTH-1:0]       fifo_mem [BUFFER_DEPTH];
   logic [LOG_BUFFER_DEPTH-1:0] wr_ptr;
   logic [LOG_BUFFER_DEPTH-1:0] rd_ptr;
   logic                        fifo_empty;
   logic                        fifo_full;
   logic                        fifo_push;
   logic                        fifo_pop;
   logic [DATA_WIDTH-1:0]       head;
   logic                        take;

   // Full/empty from wrap-bit pointers; a pop frees the slot for a same-cycle push
   always_comb begin
      fifo_empty = (wr_ptr == rd_ptr);
      fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
      fifo_pop   = take;
      fifo_push  = word_vld && (!fifo_full || fifo_pop);
      head       = fifo_mem[rd_ptr[AW-1:0]];
   end

   // FIFO storage and pointers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         for (int i = 0; i < BUFFER_DEPTH; i++) fifo_mem[i] <= '0;
      end else begin
         if (fifo_push) begin
            fifo_mem[wr_ptr[AW-1:0]] <= word_dat;
            wr_ptr <= wr_ptr + LOG_BUFFER_DEPTH'(1);
         end
         if (fifo_pop) rd_ptr <= rd_ptr + LOG_BUFFER_DEPTH'(1);
      end
   end

   // ------------------------------------------------------------------
   // SRT core. Partial remainder W is scaled so that 2^33 represents 1.0;
   // the divisor is normalised into [1/2,1) and stored doubled (d2). The
   // dividend enters below 1/2, so lz+1 digits yield the integer quotient
   // and the remainder is W shifted back down by lz+1.
   // ------------------------------------------------------------------
   core_state_t          core_state;
   logic [WW-1:0]        w;
   logic [WW-1:0]        d2;
   logic [WIDTH-1:0]     qp;         // quotient so far
   logic [WIDTH-1:0]     qm;         // quotient so far minus one
   logic [EXPWIDTH-1:0]  cnt;
   logic [EXPWIDTH-1:0]  sh;
   logic                 op_sgn;
   logic                 q_sgn;
   logic                 z_sgn;
   logic [WIDTH-1:0]     q_res;
   logic [WIDTH-1:0]     r_res;

   logic                 head_sgn;
   logic [WIDTH-1:0]     head_z;
   logic [WIDTH-1:0]     head_d;
   logic [WIDTH-1:0]     z_mag;
   logic [WIDTH-1:0]     d_mag;
   logic [EXPWIDTH-1:0]  lz;
   logic [WW-1:0]        d2_init;

   // Unpack the head entry and normalise its divisor magnitude
   always_comb begin
      head_sgn = head[DATA_WIDTH-1];
      head_z   = head[2*WIDTH-1:WIDTH];
      head_d   = head[WIDTH-1:0];
      z_mag    = head_sgn ? {1'b0, head_z[WIDTH-2:0]} : head_z;
      d_mag    = head_sgn ? {1'b0, head_d[WIDTH-2:0]} : head_d;
      lz       = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (d_mag[i]) lz = EXPWIDTH'(WIDTH - 1 - i);
      end
      d2_init  = WW'(d_mag) << (lz + EXPWIDTH'(1));
   end

   logic [WW-1:0]    w2;
   logic [WW-1:0]    w_next;
   logic [WIDTH-1:0] qp_next;
   logic [WIDTH-1:0] qm_next;

   // One SRT digit from the top three bits of 2W, with on-the-fly quotient update
   always_comb begin
      w2 = {w[WW-2:0], 1'b0};
      if (!w2[WW-1]) begin
         w_next  = w2 - d2;                       // digit +1
         qp_next = {qp[WIDTH-2:0], 1'b1};
         qm_next = {qp[WIDTH-2:0], 1'b0};
      end else if (w2[WW-1:WW-3] == 3'b111) begin
         w_next  = w2;                            // digit 0
         qp_next = {qp[WIDTH-2:0], 1'b0};
         qm_next = {qm[WIDTH-2:0], 1'b1};
      end else begin
         w_next  = w2 + d2;                       // digit -1
         qp_next = {qm[WIDTH-2:0], 1'b1};
         qm_next = {qm[WIDTH-2:0], 1'b0};
      end
   end

   logic [WW-1:0]    w_fix;
   logic [WIDTH-1:0] q_mag;
   logic [WIDTH-1:0] r_mag;
   logic [WIDTH-1:0] q_fin;
   logic [WIDTH-1:0] r_fin;

   // Negative final remainder: add the divisor back and take quotient-minus-one
   always_comb begin
      w_fix = w[WW-1] ? (w + d2) : w;
      q_mag = w[WW-1] ? qm : qp;
      r_mag = WIDTH'(w_fix >> sh);
      q_fin = op_sgn ? {q_sgn, q_mag[WIDTH-2:0]} : q_mag;
      r_fin = op_sgn ? {z_sgn, r_mag[WIDTH-2:0]} : r_mag;
   end

   // Core sequencer: load from FIFO head, iterate lz+1 digits, correct, hand over
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         core_state <= C_IDLE;
         w          <= '0;
         d2         <= '0;
         qp         <= '0;
         qm         <= '0;
         cnt        <= '0;
         sh         <= '0;
         op_sgn     <= 1'b0;
         q_sgn      <= 1'b0;
         z_sgn      <= 1'b0;
         q_res      <= '0;
         r_res      <= '0;
      end else begin
         case (core_state)
            C_IDLE: begin
               if (!fifo_empty) begin
                  op_sgn <= head_sgn;
                  q_sgn  <= head_z[WIDTH-1] ^ head_d[WIDTH-1];
                  z_sgn  <= head_z[WIDTH-1];
                  if (d_mag == '0) begin
                     q_res      <= '1;
                     r_res      <= head_z;
                     core_state <= C_DONE;
                  end else begin
                     w          <= WW'(z_mag);
                     d2         <= d2_init;
                     qp         <= '0;
                     qm         <= '1;
                     cnt        <= lz + EXPWIDTH'(1);
                     sh         <= lz + EXPWIDTH'(1);
                     core_state <= C_ITER;
                  end
               end
            end
            C_ITER: begin
               w   <= w_next;
               qp  <= qp_next;
               qm  <= qm_next;
               cnt <= cnt - EXPWIDTH'(1);
               if (cnt == EXPWIDTH'(1)) core_state <= C_CORR;
            end
            C_CORR: begin
               q_res      <= q_fin;
               r_res      <= r_fin;
               core_state <= C_DONE;
            end
            default: begin
               if (take) core_state <= C_IDLE;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Result serializer: remainder bytes then quotient bytes, LSB first
   // ------------------------------------------------------------------
   logic           ser_busy;
   logic [2:0]     ser_cnt;
   logic [SRW-1:0] ser_sr;
   logic [7:0]     out_dat;
   logic           out_pull;
   logic           out_sgn;

   // A finished result is taken when idle or while the last byte is on the bus
   always_comb begin
      take = (core_state == C_DONE) && (!ser_busy || (ser_cnt == 3'd7));
   end

   // Stream eight bytes, marking the first and holding the sign mode throughout
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ser_busy <= 1'b0;
         ser_cnt  <= '0;
         ser_sr   <= '0;
         out_dat  <= '0;
         out_pull <= 1'b0;
         out_sgn  <= 1'b0;
      end else if (take) begin
         ser_busy <= 1'b1;
         ser_cnt  <= '0;
         ser_sr   <= {q_res, r_res[WIDTH-1:8]};
         out_dat  <= r_res[7:0];
         out_pull <= 1'b1;
         out_sgn  <= op_sgn;
      end else if (ser_busy) begin
         out_pull <= 1'b0;
         if (ser_cnt == 3'd7) begin
            ser_busy <= 1'b0;
            out_dat  <= '0;
            out_sgn  <= 1'b0;
         end else begin
            ser_cnt  <= ser_cnt + 3'd1;
            out_dat  <= ser_sr[7:0];
            ser_sr   <= ser_sr >> 8;
         end
      end
   end

   assign bus.data_out_out = out_dat;
   assign bus.pull_out     = out_pull;
   assign bus.sign_out     = out_sgn;

endmodule

// File: tb/tb_divider_top.sv
// Self-checking bench for divider_top: directed cases, random sweep, overflow drop, mid-op reset.
// Results are compared against a plain-arithmetic reference and the z = d*q + r identity.
// The bench never stalls the DUT; every wait is bounded.
module tb_divider_top;

   typedef struct {
      logic        sgn;
      logic [31:0] z;
      logic [31:0] d;
   } op_t;

   logic clk = 1'b0;
   logic rst_n;
   int   cyc = 0;
   int   tests = 0;
   int   fails = 0;
   int   rcv_cnt = 0;
   int   push_cyc = 0;
   int   pull_cyc = 0;
   op_t  exp_q[$];

   divider_top_if bus ();

   divider_top dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Reference divide: {q, r} straight from the arithmetic definition
   function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] z, input logic [31:0] d);
      logic [31:0] zm, dm, q, r;
      zm = sgn ? {1'b0, z[30:0]} : z;
      dm = sgn ? {1'b0, d[30:0]} : d;
      if (dm == 32'd0) return {32'hFFFF_FFFF, z};
      q = zm / dm;
      r = zm % dm;
      if (sgn) begin
         q[31] = z[31] ^ d[31];
         r[31] = z[31];
      end
      return {q, r};
   endfunction

   task automatic push_op(input logic sgn, input logic [31:0] z, input logic [31:0] d, input bit expect_it);
      logic [63:0] w;
      op_t o;
      w = {z, d};
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         bus.data_in_in = w[63 - 8*i -: 8];
         bus.push_in    = 1'b1;
         bus.sign       = sgn;
         bus.select     = 1'($urandom_range(0, 1));
      end
      push_cyc = cyc + 1;
      if (expect_it) begin
         o.sgn = sgn;
         o.z   = z;
         o.d   = d;
         exp_q.push_back(o);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         bus.push_in = 1'b0;
      end
   endtask

   task automatic drain(input string tag);
      int n = 0;
      while (exp_q.size() != 0 && n < 400) begin
         @(negedge clk);
         n++;
      end
      check_eq(tag, 64'(exp_q.size()), 64'd0);
   endtask

   // Result collector: assembles each 8-byte stream and scores it
   initial begin : collector
      logic [63:0] got, expv;
      logic        s0;
      bit          pull_ok, sign_ok;
      logic [31:0] zm, dm, qm, rm;
      op_t         o;
      forever begin
         @(negedge clk);
         if (rst_n === 1'b1 && bus.pull_out === 1'b1) begin
            pull_cyc  = cyc;
            got[7:0]  = bus.data_out_out;
            s0        = bus.sign_out;
            pull_ok   = 1'b1;
            sign_ok   = 1'b1;
            for (int k = 1; k < 8; k++) begin
               @(negedge clk);
               got[8*k +: 8] = bus.data_out_out;
               if (bus.pull_out !== 1'b0) pull_ok = 1'b0;
               if (bus.sign_out !== s0)   sign_ok = 1'b0;
            end
            rcv_cnt++;
            if (exp_q.size() == 0) begin
               check_eq("unexpected_result", got, 64'd0);
            end else begin
               o    = exp_q.pop_front();
               expv = ref_div(o.sgn, o.z, o.d);
               check_eq("result_qr", got, expv);
               check_eq("sign_out", 64'(s0), 64'(o.sgn));
               check_eq("pull_once", 64'(pull_ok), 64'd1);
               check_eq("sign_hold", 64'(sign_ok), 64'd1);
               zm = o.sgn ? {1'b0, o.z[30:0]} : o.z;
               dm = o.sgn ? {1'b0, o.d[30:0]} : o.d;
               qm = o.sgn ? {1'b0, got[62:32]} : got[63:32];
               rm = o.sgn ? {1'b0, got[30:0]}  : got[31:0];
               if (dm != 32'd0) begin
                  check_eq("z_eq_dq_r", 64'(zm), 64'(dm) * 64'(qm) + 64'(rm));
                  check_eq("r_lt_d", 64'(rm < dm), 64'd1);
               end
            end
         end
      end
   end

   initial begin : watchdog
      repeat (60000) @(posedge clk);
      $display("FAIL watchdog cycles=%0d pending=%0d", cyc, exp_q.size());
      $fatal(1);
   end

   initial begin : main
      int base;
      logic [31:0] z, d;
      logic sgn;

      bus.data_in_in = 8'h00;
      bus.push_in    = 1'b0;
      bus.sign       = 1'b0;
      bus.select     = 1'b0;
      rst_n          = 1'b0;
      repeat (3) @(negedge clk);
      check_eq("rst_data", 64'(bus.data_out_out), 64'd0);
      check_eq("rst_pull", 64'(bus.pull_out), 64'd0);
      check_eq("rst_sign", 64'(bus.sign_out), 64'd0);
      rst_n = 1'b1;
      idle(2);

      // Directed cases from an empty FIFO
      push_op(1'b0, 32'h0000_0064, 32'h0000_0007, 1'b1);
      idle(1);
      drain("drain_100_7");
      check_eq("latency_le_40", 64'((pull_cyc - push_cyc) <= 40), 64'd1);
      push_op(1'b1, 32'h8000_0064, 32'h0000_0007, 1'b1); idle(1); drain("drain_signed");
      push_op(1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1); idle(1); drain("drain_ff_1");
      push_op(1'b0, 32'h0000_0005, 32'h0000_0009, 1'b1); idle(1); drain("drain_5_9");
      push_op(1'b0, 32'h0000_F000, 32'h0000_0010, 1'b1); idle(1); drain("drain_f000");
      push_op(1'b0, 32'h1234_5678, 32'h0000_0000, 1'b1); idle(1); drain("drain_div0_u");
      push_op(1'b1, 32'h1234_5678, 32'h0000_0000, 1'b1); idle(1); drain("drain_div0_s");
      push_op(1'b1, 32'h0000_0003, 32'h8000_0007, 1'b1); idle(1); drain("drain_zero_q_sign");

      // Random sweep with divisors of 0-3 leading zero bytes
      for (int i = 0; i < 80; i++) begin
         z   = $urandom;
         d   = $urandom >> (8 * $urandom_range(0, 3));
         if (i % 10 == 3) z = z >> $urandom_range(0, 31);
         sgn = 1'($urandom_range(0, 1));
         push_op(sgn, z, d, 1'b1);
         idle(100);
      end
      drain("drain_sweep");

      // Five ops back-to-back: the first divides by 1 and holds the core long
      // enough that the FIFO is full when the fifth arrives
      base = rcv_cnt;
      push_op(1'b0, $urandom, 32'h0000_0001, 1'b1);
      push_op(1'b0, $urandom, $urandom >> 4, 1'b1);
      push_op(1'b1, $urandom, $urandom >> 12, 1'b1);
      push_op(1'b0, $urandom, $urandom, 1'b1);
      push_op(1'b0, $urandom, $urandom, 1'b0);
      idle(1);
      drain("drain_b2b");
      idle(80);
      check_eq("b2b_count", 64'(rcv_cnt - base), 64'd4);

      // Reset after five bytes of an operation, then a clean operation
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         bus.data_in_in = 8'hA5;
         bus.push_in    = 1'b1;
      end
      @(negedge clk);
      bus.push_in = 1'b0;
      rst_n       = 1'b0;
      @(negedge clk);
      check_eq("midrst_data", 64'(bus.data_out_out), 64'd0);
      check_eq("midrst_pull", 64'(bus.pull_out), 64'd0);
      check_eq("midrst_sign", 64'(bus.sign_out), 64'd0);
      rst_n = 1'b1;
      idle(2);
      push_op(1'b0, 32'h0000_0064, 32'h0000_0007, 1'b1);
      idle(1);
      drain("drain_after_rst");
      idle(20);
      check_eq("pending_final", 64'(exp_q.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
